// File: rtl/mux2_product_pipe_if.sv
// Stream bundle for mux2_product_pipe: the product-typed channel inputs and select,
// the registered FIFO-head outputs, and the error/status flags.
interface mux2_product_pipe_if #(
  parameter int N_IN    = 2,
  parameter int A_WIDTH = 1,
  parameter int B_WIDTH = 8,
  parameter int SEL_W   = 1
);
  logic [N_IN*A_WIDTH-1:0] I_a;
  logic [N_IN*B_WIDTH-1:0] I_b;
  logic [SEL_W-1:0]        S;
  logic                    in_valid;
  logic                    in_ready;
  logic [A_WIDTH-1:0]      O_a;
  logic [B_WIDTH-1:0]      O_b;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic [7:0]              err_count;

  // Environment side: produces beats and consumes the FIFO head.
  modport master (
    output I_a, I_b, S, in_valid, out_ready,
    input  in_ready, O_a, O_b, out_valid, sel_err, err_count
  );

  // Block side.
  modport slave (
    input  I_a, I_b, S, in_valid, out_ready,
    output in_ready, O_a, O_b, out_valid, sel_err, err_count
  );
endinterface

// File: rtl/mux2_product_pipe.sv
// Pipelined product-type N:1 mux: selects {a,b} from one of N_IN channels per accepted
// beat and queues it in a DEPTH-entry FIFO; out-of-range selects are dropped and counted.
module mux2_product_pipe #(
  parameter int N_IN    = 2,
  parameter int A_WIDTH = 1,
  parameter int B_WIDTH = 8,
  parameter int DEPTH   = 2,
  parameter int SEL_W   = (N_IN > 2) ? $clog2(N_IN) : 1
) (
  input  logic                CLK,
  input  logic                ASYNCRESETN,
  mux2_product_pipe_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [A_WIDTH-1:0] mem_a_q [DEPTH];
  logic [B_WIDTH-1:0] mem_b_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               live_q;
  logic               sel_err_q;
  logic [7:0]         err_cnt_q;

  logic [A_WIDTH-1:0] sel_a;
  logic [B_WIDTH-1:0] sel_b;
  logic               sel_ok;
  logic               full, pop, accept, push;

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_ok = 1'b0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (bus.S == SEL_W'(k)) begin
        sel_a  = bus.I_a[k*A_WIDTH +: A_WIDTH];
        sel_b  = bus.I_b[k*B_WIDTH +: B_WIDTH];
        sel_ok = 1'b1;
      end
    end
  end

  // live_q holds in_ready low from reset assertion until the first edge after release.
  assign full          = (count_q == CNT_W'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.in_ready  = live_q & (~full | pop);
  assign accept        = bus.in_valid & bus.in_ready;
  assign push          = accept & sel_ok;

  assign bus.O_a       = mem_a_q[rd_ptr_q];
  assign bus.O_b       = mem_b_q[rd_ptr_q];
  assign bus.sel_err   = sel_err_q;
  assign bus.err_count = err_cnt_q;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem_a_q[k] <= '0;
        mem_b_q[k] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      live_q    <= 1'b0;
      sel_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      live_q <= 1'b1;
      if (push) begin
        mem_a_q[wr_ptr_q] <= sel_a;
        mem_b_q[wr_ptr_q] <= sel_b;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (accept && !sel_ok) begin
        sel_err_q <= 1'b1;
        if (err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux2_product_pipe.sv
// Directed bench for mux2_product_pipe: a 4-channel and a 3-channel instance, both
// DEPTH=2, checked against hand-computed values and a small in-order scoreboard.
module tb_mux2_product_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mux2_product_pipe_if #(.N_IN(4), .A_WIDTH(1), .B_WIDTH(8), .SEL_W(2)) b4 ();
  mux2_product_pipe_if #(.N_IN(3), .A_WIDTH(1), .B_WIDTH(8), .SEL_W(2)) b3 ();

  mux2_product_pipe #(.N_IN(4), .A_WIDTH(1), .B_WIDTH(8), .DEPTH(2), .SEL_W(2)) u_d4 (
    .CLK(clk), .ASYNCRESETN(rst_n), .bus(b4)
  );
  mux2_product_pipe #(.N_IN(3), .A_WIDTH(1), .B_WIDTH(8), .DEPTH(2), .SEL_W(2)) u_d3 (
    .CLK(clk), .ASYNCRESETN(rst_n), .bus(b3)
  );

  logic [8:0]  q[$];
  logic [8:0]  held;
  logic        stalled, acc;
  logic [3:0]  bi;
  logic [1:0]  s;
  int unsigned i, got, cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b4.I_a = '0; b4.I_b = '0; b4.S = '0; b4.in_valid = 1'b0; b4.out_ready = 1'b0;
    b3.I_a = '0; b3.I_b = '0; b3.S = '0; b3.in_valid = 1'b0; b3.out_ready = 1'b0;

    // Reset state and release
    #12;
    check("rst_in_ready",  b4.in_ready,  0);
    check("rst_out_valid", b4.out_valid, 0);
    check("rst_O_b",       b4.O_b,       0);
    check("rst_err_count", b3.err_count, 0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_before_edge", b4.in_ready, 0);
    tick();
    check("rel_in_ready_after_edge", b4.in_ready, 1);

    // Single beat, ch2 of four
    b4.I_b = 32'h44A5_2211; b4.I_a = 4'b0100; b4.S = 2'd2;
    b4.in_valid = 1'b1; b4.out_ready = 1'b1;
    tick();
    b4.in_valid = 1'b0;
    check("t2_valid", b4.out_valid, 1);
    check("t2_O_b",   b4.O_b,       8'hA5);
    check("t2_O_a",   b4.O_a,       1);
    tick();
    check("t2_drained", b4.out_valid, 0);

    // Fill, back-pressure, then push on full with simultaneous pop
    b4.out_ready = 1'b0; b4.I_a = 4'b1010; b4.I_b = 32'h4433_2211;
    b4.in_valid = 1'b1; b4.S = 2'd0;
    tick();
    b4.S = 2'd1;
    tick();
    b4.S = 2'd3;
    #1;
    check("t3_full_ready", b4.in_ready,  0);
    check("t3_valid",      b4.out_valid, 1);
    check("t3_head0",      b4.O_b,       8'h11);
    tick();
    check("t3_head_held",  b4.O_b,       8'h11);
    b4.out_ready = 1'b1;
    #1;
    check("t4_ready_on_pop", b4.in_ready, 1);
    tick();
    b4.in_valid = 1'b0;
    check("t4_head1_b", b4.O_b, 8'h22);
    check("t4_head1_a", b4.O_a, 1);
    b4.out_ready = 1'b0;
    #1;
    check("t4_still_full", b4.in_ready, 0);
    b4.out_ready = 1'b1;
    tick();
    check("t4_head3_b",  b4.O_b,       8'h44);
    check("t4_head3_a",  b4.O_a,       1);
    check("t4_head3_v",  b4.out_valid, 1);
    tick();
    check("t4_drained",  b4.out_valid, 0);
    b4.out_ready = 1'b0;

    // Out-of-range select on the 3-channel instance
    b3.I_b = 24'h33_2211; b3.I_a = 3'b010; b3.out_ready = 1'b1;
    b3.S = 2'd1; b3.in_valid = 1'b1;
    tick();
    b3.in_valid = 1'b0;
    check("t5_good_b",   b3.O_b,       8'h22);
    check("t5_good_v",   b3.out_valid, 1);
    check("t5_good_err", b3.sel_err,   0);
    tick();
    b3.S = 2'd3; b3.in_valid = 1'b1;
    #1;
    check("t5_bad_ready", b3.in_ready, 1);
    tick();
    b3.in_valid = 1'b0;
    check("t5_no_push",  b3.out_valid, 0);
    check("t5_sel_err",  b3.sel_err,   1);
    check("t5_err_1",    b3.err_count, 1);
    b3.in_valid = 1'b1;
    repeat (253) tick();
    check("t5_err_254",  b3.err_count, 8'hFE);
    repeat (46) tick();
    b3.in_valid = 1'b0;
    check("t5_err_sat",  b3.err_count, 8'hFF);
    tick();
    check("t5_err_hold", b3.err_count, 8'hFF);
    check("t5_sticky",   b3.sel_err,   1);
    check("t5_empty",    b3.out_valid, 0);

    // 16 back-to-back beats with random output stalls
    i = 0; got = 0; cyc = 0;
    while (got < 16 && cyc < 300) begin
      b4.out_ready = ($urandom_range(0, 2) != 0);
      b4.in_valid  = (i < 16);
      bi = 4'(i);
      s  = 2'((i * 3 + 1) % 4);
      b4.S   = s;
      b4.I_b = {bi, 4'd3, bi, 4'd2, bi, 4'd1, bi, 4'd0};
      b4.I_a = bi[0] ? 4'b0101 : 4'b1010;
      #1;
      check("t6_valid", b4.out_valid, q.size() != 0);
      check("t6_ready", b4.in_ready, (q.size() < 2) || (b4.out_ready && q.size() != 0));
      acc     = b4.in_valid & b4.in_ready;
      stalled = b4.out_valid & ~b4.out_ready;
      held    = {b4.O_a, b4.O_b};
      if (b4.out_valid && b4.out_ready && q.size() != 0) begin
        check("t6_data", {b4.O_a, b4.O_b}, q[0]);
        void'(q.pop_front());
        got++;
      end
      tick();
      if (acc) begin
        q.push_back({s[0] ^ bi[0], bi, 2'b00, s});
        i++;
      end
      if (stalled) check("t6_hold", {b4.O_a, b4.O_b}, held);
      cyc++;
    end
    b4.in_valid = 1'b0;
    check("t6_count", got, 16);

    // Reset mid-cycle with a beat in flight and sticky errors set
    b4.out_ready = 1'b0; b4.I_b = 32'h4433_2211; b4.S = 2'd1; b4.in_valid = 1'b1;
    tick();
    b4.in_valid = 1'b0;
    check("t1_pre_valid", b4.out_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    check("t1_valid",     b4.out_valid, 0);
    check("t1_O_b",       b4.O_b,       0);
    check("t1_in_ready",  b4.in_ready,  0);
    check("t1_sel_err",   b3.sel_err,   0);
    check("t1_err_count", b3.err_count, 0);
    #10 rst_n = 1'b1;
    tick();
    check("t1_in_ready_rel", b4.in_ready,  1);
    check("t1_lost_beat",    b4.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
